// File: rtl/counter_months_pkg.sv
// Shared types, limits and BCD month step helpers for counter_months.
package counter_months_pkg;

  localparam int unsigned MONTH_MIN = 1;
  localparam int unsigned MONTH_MAX = 12;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t ten;
    bcd_t unit;
  } month_t;

  localparam month_t MonthMin = '{ten: bcd_t'(MONTH_MIN / 10), unit: bcd_t'(MONTH_MIN % 10)};
  localparam month_t MonthMax = '{ten: bcd_t'(MONTH_MAX / 10), unit: bcd_t'(MONTH_MAX % 10)};
  localparam bcd_t   BcdNine  = bcd_t'(9);
  localparam bcd_t   BcdOne   = bcd_t'(1);

  function automatic month_t month_inc(month_t m);
    month_t r;
    if (m == MonthMax) begin
      r = MonthMin;
    end else if (m.unit == BcdNine) begin
      r.ten  = m.ten + BcdOne;
      r.unit = '0;
    end else begin
      r.ten  = m.ten;
      r.unit = m.unit + BcdOne;
    end
    return r;
  endfunction

  function automatic month_t month_dec(month_t m);
    month_t r;
    if (m == MonthMin) begin
      r = MonthMax;
    end else if (m.unit == '0) begin
      r.ten  = m.ten - BcdOne;
      r.unit = BcdNine;
    end else begin
      r.ten  = m.ten;
      r.unit = m.unit - BcdOne;
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_months_edge.sv
// One-bit rising-edge detector against the previous-cycle sampled value.
module counter_months_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= d;
    end
  end

  assign rise = d & ~hist_q;

endmodule

// File: rtl/counter_months.sv
// BCD month counter 01..12 with run (tick_month) and adjust (up/down) modes.
// Define COUNTER_MONTHS_EDGE_EN to make up/down act on rising edges only.
module counter_months
  import counter_months_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_month,
  input  logic       up,
  input  logic       down,
  input  logic       tick_month,
  output logic [3:0] month_unit,
  output logic [3:0] month_ten,
  output logic       tick_year
);

  month_t month_q, month_d;
  logic   tick_year_q, tick_year_d;
  logic   up_evt, down_evt;

`ifdef COUNTER_MONTHS_EDGE_EN
  counter_months_edge u_edge_up (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (up),
    .rise (up_evt)
  );

  counter_months_edge u_edge_down (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (down),
    .rise (down_evt)
  );
`else
  assign up_evt   = up;
  assign down_evt = down;
`endif

  always_comb begin
    month_d     = month_q;
    tick_year_d = 1'b0;
    if (mode_month) begin
      if (tick_month) begin
        month_d     = month_inc(month_q);
        tick_year_d = (month_q == MonthMax);
      end
    end else if (up_evt && !down_evt) begin
      month_d = month_inc(month_q);
    end else if (down_evt && !up_evt) begin
      month_d = month_dec(month_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      month_q     <= MonthMin;
      tick_year_q <= 1'b0;
    end else begin
      month_q     <= month_d;
      tick_year_q <= tick_year_d;
    end
  end

  assign month_ten  = month_q.ten;
  assign month_unit = month_q.unit;
  assign tick_year  = tick_year_q;

endmodule

// File: tb/tb_counter_months.sv
// Randomized + directed bench for counter_months against an integer month model.
module tb_counter_months;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode_month, up, down, tick_month;
  logic [3:0] month_unit, month_ten;
  logic       tick_year;

  counter_months dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_month(mode_month),
    .up        (up),
    .down      (down),
    .tick_month(tick_month),
    .month_unit(month_unit),
    .month_ten (month_ten),
    .tick_year (tick_year)
  );

  always #5 clk = ~clk;

`ifdef COUNTER_MONTHS_EDGE_EN
  localparam bit EdgeMode = 1'b1;
`else
  localparam bit EdgeMode = 1'b0;
`endif

  // Reference model: month as a plain integer 1..12.
  int m      = 1;
  bit exp_ty = 1'b0;
  bit prev_up = 1'b0, prev_dn = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m = 1; exp_ty = 1'b0; prev_up = 1'b0; prev_dn = 1'b0;
    end else begin
      bit eu, ed;
      eu = EdgeMode ? (up && !prev_up) : up;
      ed = EdgeMode ? (down && !prev_dn) : down;
      exp_ty = 1'b0;
      if (mode_month) begin
        if (tick_month) begin
          if (m == 12) begin m = 1; exp_ty = 1'b1; end
          else m = m + 1;
        end
      end else if (eu && !ed) begin
        m = (m == 12) ? 1 : m + 1;
      end else if (ed && !eu) begin
        m = (m == 1) ? 12 : m - 1;
      end
      prev_up = up;
      prev_dn = down;
    end
  end

  // Hand-computed literal expectations, consumed by the compare process.
  int pin_m = 1;
  bit pin_t = 1'b0;
  int pin_seq = 0;
  int pin_seen = 0;

  int errors = 0;
  int checks = 0;

  always @(negedge clk) begin
    logic [3:0] et, eun;
    et  = 4'(m / 10);
    eun = 4'(m % 10);
    checks++;
    if (month_ten !== et || month_unit !== eun || tick_year !== exp_ty) begin
      errors++;
      $display("FAIL model t=%0t got=%h%h ty=%b want=%h%h ty=%b",
               $time, month_ten, month_unit, tick_year, et, eun, exp_ty);
    end
    if (pin_seq != pin_seen) begin
      pin_seen = pin_seq;
      et  = 4'(pin_m / 10);
      eun = 4'(pin_m % 10);
      checks++;
      if (month_ten !== et || month_unit !== eun || tick_year !== pin_t) begin
        errors++;
        $display("FAIL literal#%0d t=%0t got=%h%h ty=%b want=%h%h ty=%b",
                 pin_seq, $time, month_ten, month_unit, tick_year, et, eun, pin_t);
      end
    end
  end

  task automatic pin(input int mm, input bit tt);
    pin_m = mm;
    pin_t = tt;
    pin_seq++;
  endtask

  task automatic step(input bit md, input bit u, input bit d, input bit t);
    mode_month = md; up = u; down = d; tick_month = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mode_month = 1'b0; up = 1'b0; down = 1'b0; tick_month = 1'b0;
    #3 pin(1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Run mode from 01, 20 ticks: wrap on 12th edge, end at 09.
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      if (i == 9)  pin(10, 1'b0);
      if (i == 11) pin(12, 1'b0);
      if (i == 12) pin(1, 1'b1);
    end
    pin(9, 1'b0);

    // Run mode, no tick, up/down toggling: hold.
    for (int i = 0; i < 20; i++) step(1'b1, 1'(i % 2), 1'((i + 1) % 2), 1'b0);
    pin(9, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Adjust mode, up and down together: hold.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    pin(9, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Adjust up 20 then down 20.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    pin(EdgeMode ? 10 : 5, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    pin(9, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Adjust down wrap 01->12 without tick_year.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    pin(1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    pin(12, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // tick_month ignored in adjust mode.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    pin(12, 1'b0);

    // Mode switch takes effect on first edge; 12->01 wrap with pulse.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    pin(1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    pin(2, 1'b0);

    // Async reset mid-operation with tick held; edge during reset is ignored.
    rst_n = 1'b0;
    pin(1, 1'b0);
    @(posedge clk); #1;
    pin(1, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    pin(2, 1'b0);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      step(1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 3) != 0));
    end

    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_months.md
COUNTER_MONTHS -- requirements
Module: counter_months

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the following ports.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 mode_month  input  1  1 = run mode (advance on tick_month); 0 = adjust mode (step via up/down).
REQ-005 up  input  1  adjust-mode increment request.
REQ-006 down  input  1  adjust-mode decrement request.
REQ-007 tick_month  input  1  run-mode month-advance strobe, sampled every clk edge.
REQ-008 month_unit  output  4  BCD units digit of the current month, registered.
REQ-009 month_ten  output  4  BCD tens digit of the current month (0 or 1), registered.
REQ-010 tick_year  output  1  registered one-cycle pulse on a run-mode 12->01 wrap.

Function
REQ-011 The month value SHALL always be in the range 01..12 BCD; month_ten SHALL be 0 for 01..09 and 1 for 10..12; codes 00 and 13..99 SHALL never appear.
REQ-012 Run mode (mode_month=1), tick_month=1 at an edge: month SHALL advance by 1 on that edge; 09->10 carries to tens; 12 SHALL wrap to 01.
REQ-013 Run mode, tick_month=1 held for N cycles: month SHALL advance once per cycle, N steps total.
REQ-014 Run mode: up and down SHALL be ignored.
REQ-015 On the edge where a run-mode 12->01 wrap occurs, tick_year SHALL be set to 1 for exactly one cycle, coincident with month reading 01; otherwise it SHALL be 0.
REQ-016 Adjust mode (mode_month=0): tick_month SHALL be ignored.
REQ-017 Adjust mode, up=1 and down=0: month SHALL increment with wrap 12->01.
REQ-018 Adjust mode, down=1 and up=0: month SHALL decrement with wrap 01->12.
REQ-019 Adjust mode, up=1 and down=1 together: month SHALL hold.
REQ-020 Adjust mode, up=0 and down=0: month SHALL hold.
REQ-021 Adjust-mode wraps SHALL NOT assert tick_year.
REQ-022 A mode_month change SHALL take effect at the first edge sampling the new value, with no extra latency and no spurious step.
REQ-023 Latency: every output change SHALL be visible immediately after the triggering clk edge, with no combinational input-to-output paths.

Reset
REQ-024 rst_n=0 SHALL immediately, independent of clk, set month_ten=0, month_unit=1 (month 01) and tick_year=0.
REQ-025 When COUNTER_MONTHS_EDGE_EN is defined, rst_n=0 SHALL also clear the edge-detector history registers to 0.
REQ-026 Reset asserted mid-operation SHALL abort any pending step.
REQ-027 The first step after rst_n deasserts SHALL occur no earlier than the first rising clk edge with rst_n=1.

Configuration
REQ-028 Macro COUNTER_MONTHS_EDGE_EN undefined (default): up and down SHALL be level-sensitive, giving one step per clock cycle while asserted.
REQ-029 Macro COUNTER_MONTHS_EDGE_EN defined: up and down SHALL act only on their rising edge, detected against the previous-cycle sampled value, giving one step per press regardless of hold time.
REQ-030 With COUNTER_MONTHS_EDGE_EN defined, simultaneous rising edges on up and down SHALL cause a hold.

Structure
REQ-031 Package counter_months_pkg SHALL hold the constants MONTH_MIN=1 and MONTH_MAX=12 and a 4-bit BCD digit typedef; the block SHALL use these instead of literal values.
REQ-032 The month SHALL be held internally as a BCD tens/units register pair driving the outputs directly.
REQ-033 Sub-module counter_months_edge, a one-bit rising-edge detector, SHALL be instantiated twice (up, down) only when COUNTER_MONTHS_EDGE_EN is defined.

Verification
REQ-034 Reset: assert rst_n=0 -> month_ten=0, month_unit=1, tick_year=0 with no clock edge required.
REQ-035 Run mode from 01, tick_month=1 for 20 cycles -> exactly one tick_year pulse, on the 12th edge (month 01); final month 09.
REQ-036 Run mode, tick_month=0 for 20 cycles with up/down toggling -> month stays 09, tick_year stays 0.
REQ-037 Adjust mode from 09, up=1 and down=1 for 20 cycles -> month stays 09.
REQ-038 Adjust mode, level default: up=1 for 20 cycles -> month 05 and no tick_year; then down=1 for 20 cycles -> month 09.
REQ-039 With COUNTER_MONTHS_EDGE_EN defined, from 09: up held 20 cycles -> month 10; tick_month in adjust mode -> no change.
